cordic_z_pipe: RTL and testbench

- Parametrised, fully pipelined Z (angle) channel of the CORDIC engine, generalising the single-stage Z add/sub into STAGES chained micro-rotation stages.
- Each stage has an internal arctan constant. Rotation or vectoring mode is selected per sample.
- Exports per-stage direction bits so the X/Y datapath stays cycle-aligned.
- Sits between the angle front end and the CORDIC output formatter.

---
 rtl/cordic_z_pipe.sv | 98 +++++++++
 tb/tb_cordic_z_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_z_pipe.sv
// Fully pipelined CORDIC angle (Z) channel: STAGES micro-rotation stages with
// elaboration-time arctan constants and per-stage direction export for the XY path.
module cordic_z_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Valid_i,
  input  logic              Mode_i,
  input  logic [WIDTH-1:0]  Z_i,
  input  logic [STAGES-1:0] Dir_i,
  output logic              Valid_o,
  output logic              Mode_o,
  output logic [WIDTH-1:0]  Cordic_z,
  output logic [STAGES-1:0] Dir_o,
  output logic              Busy
);

  localparam int unsigned FRAC   = 62 - WIDTH;
  localparam logic [63:0] PI_Q61 = 64'h6487_ED51_10B4_611A;

  // round(atan(2^-k)/pi * 2^(WIDTH-1)) via a fixed-point Taylor series in Q(FRAC).
  function automatic logic [WIDTH-1:0] atan_const(input int unsigned k);
    logic [63:0] acc;
    logic [63:0] term;
    logic [63:0] q;
    int          sh;
    acc = '0;
    if (k == 0) begin
      q = 64'd1 << (WIDTH - 3);
    end else begin
      for (int n = 1; n < 64; n += 2) begin
        sh = int'(FRAC) - int'(k) * n;
        if (sh >= 0) begin
          term = (64'd1 << sh) / 64'(n);
          if ((n % 4) == 1) acc = acc + term;
          else              acc = acc - term;
        end
      end
      q = (((acc << WIDTH) / (PI_Q61 >> (WIDTH - 1))) + 64'd1) >> 1;
    end
    return WIDTH'(q);
  endfunction

  logic [STAGES-1:0] valid_vec;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] ATAN_K = atan_const(k);

    logic [WIDTH-1:0] z_in;
    logic [WIDTH-1:0] z_d;
    logic [WIDTH-1:0] z_q;
    logic             mode_in;
    logic             valid_in;
    logic             dir_c;
    logic             mode_q;
    logic             valid_q;

    if (k == 0) begin : g_head
      assign z_in     = Z_i;
      assign mode_in  = Mode_i;
      assign valid_in = Valid_i;
    end else begin : g_link
      assign z_in     = g_stage[k-1].z_q;
      assign mode_in  = g_stage[k-1].mode_q;
      assign valid_in = g_stage[k-1].valid_q;
    end

    // Rotation steers z toward zero; vectoring takes its direction from the XY path.
    always_comb begin
      dir_c = mode_in ? Dir_i[k] : ~z_in[WIDTH-1];
      z_d   = dir_c ? (z_in - ATAN_K) : (z_in + ATAN_K);
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        z_q     <= '0;
        mode_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (Enable) begin
        z_q     <= z_d;
        mode_q  <= mode_in;
        valid_q <= valid_in;
      end
    end

    assign Dir_o[k]     = dir_c;
    assign valid_vec[k] = valid_q;
  end

  assign Cordic_z = g_stage[STAGES-1].z_q;
  assign Mode_o   = g_stage[STAGES-1].mode_q;
  assign Valid_o  = g_stage[STAGES-1].valid_q;
  assign Busy     = |valid_vec;

endmodule

// File: tb/tb_cordic_z_pipe.sv
// Self-checking bench for cordic_z_pipe (WIDTH=16, STAGES=16): scoreboard of
// expected angles and arrival edges, plus per-scenario inline checks.
module tb_cordic_z_pipe;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 16;
  localparam int ATAN_TAB [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                   41, 20, 10, 5, 3, 1, 1, 0};

  logic              Clk;
  logic              Reset;
  logic              Enable;
  logic              Valid_i;
  logic              Mode_i;
  logic [WIDTH-1:0]  Z_i;
  logic [STAGES-1:0] Dir_i;
  logic              Valid_o;
  logic              Mode_o;
  logic [WIDTH-1:0]  Cordic_z;
  logic [STAGES-1:0] Dir_o;
  logic              Busy;

  typedef struct {
    logic [15:0] z;
    logic        mode;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int unsigned en_edges;
  logic        last_en;
  int          n_out;
  logic [15:0] last_z;

  cordic_z_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Valid_i(Valid_i),
    .Mode_i(Mode_i), .Z_i(Z_i), .Dir_i(Dir_i), .Valid_o(Valid_o),
    .Mode_o(Mode_o), .Cordic_z(Cordic_z), .Dir_o(Dir_o), .Busy(Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference: sequential micro-rotations with the tabulated constants.
  function automatic logic [15:0] model(input logic [15:0] z_in, input logic mode,
                                        input logic [15:0] dirs);
    logic [15:0] z;
    logic        d;
    z = z_in;
    for (int k = 0; k < 16; k++) begin
      d = mode ? dirs[k] : ~z[15];
      if (d) z = z - 16'(ATAN_TAB[k]);
      else   z = z + 16'(ATAN_TAB[k]);
    end
    return z;
  endfunction

  always @(posedge Clk) begin
    last_en <= Enable && Reset;
    if (Enable && Reset) en_edges <= en_edges + 1;
  end

  // Scoreboard monitor: one comparison per newly produced valid output.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset && last_en && Valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: z=%h mode=%b edge=%0d, none expected",
                 Cordic_z, Mode_o, en_edges);
      end else begin
        e = sb.pop_front();
        if (Cordic_z !== e.z || Mode_o !== e.mode || en_edges !== e.edge_no) begin
          errors++;
          $display("FAIL output: z=%h mode=%b edge=%0d, want z=%h mode=%b edge=%0d",
                   Cordic_z, Mode_o, en_edges, e.z, e.mode, e.edge_no);
        end
      end
      n_out++;
      last_z = Cordic_z;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] z, input logic mode);
    exp_t e;
    Valid_i   = 1'b1;
    Mode_i    = mode;
    Z_i       = z;
    e.z       = model(z, mode, Dir_i);
    e.mode    = mode;
    e.edge_no = en_edges + 16;
    sb.push_back(e);
  endtask

  task automatic idle();
    Valid_i = 1'b0;
    Mode_i  = 1'($urandom);
    Z_i     = 16'($urandom);
  endtask

  task automatic drain(input string name);
    idle();
    for (int i = 0; i < 64 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results pending, want 0", name, sb.size());
    end
    repeat (2) step();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_idle: Busy=%b, want 0", name, Busy);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (Valid_o !== 1'b0 || Mode_o !== 1'b0 || Cordic_z !== 16'h0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b mode=%b z=%h busy=%b, want 0 0 0000 0",
               Valid_o, Mode_o, Cordic_z, Busy);
    end
    checks++;
    if (Dir_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_dir: Dir_o=%h, want ffff", Dir_o);
    end
    step();
    Reset  = 1'b1;
    Enable = 1'b1;
  endtask

  task automatic test_rotation();
    int          start;
    logic signed [15:0] s;
    start = n_out;
    drive(16'd8192, 1'b0);
    #1;
    checks++;
    if (Dir_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL rot_dir0: Dir_o[0]=%b, want 1", Dir_o[0]);
    end
    step();
    drain("rotation");
    s = last_z;
    checks++;
    if (n_out - start != 1 || s > 16'sd8 || s < -16'sd8) begin
      errors++;
      $display("FAIL rot_residual: outputs=%0d z=%0d, want 1 output with |z|<=8",
               n_out - start, s);
    end
  endtask

  task automatic test_vectoring();
    drive(16'h0000, 1'b1);
    step();
    drain("vec0");
    checks++;
    if (last_z !== 16'hB8FA) begin
      errors++;
      $display("FAIL vec_zero: z=%h, want b8fa", last_z);
    end
    drive(16'h8000, 1'b1);
    step();
    drain("vecwrap");
    checks++;
    if (last_z !== 16'd14586) begin
      errors++;
      $display("FAIL vec_wrap: z=%0d, want 14586", last_z);
    end
  endtask

  task automatic test_stall();
    logic [15:0] vals [4];
    logic [15:0] snap;
    int          start;
    vals  = '{16'd1000, 16'hF830, 16'd12345, 16'h8AD0};
    start = n_out;
    for (int i = 0; i < 4; i++) begin
      drive(vals[i], 1'b0);
      if (i == 1) begin
        #1;
        checks++;
        if (Dir_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL stall_dir0_neg: Dir_o[0]=%b, want 0", Dir_o[0]);
        end
      end
      step();
    end
    idle();
    repeat (13) step();
    Enable = 1'b0;
    snap   = Cordic_z;
    checks++;
    if (Valid_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre_valid: Valid_o=%b, want 1", Valid_o);
    end
    Valid_i = 1'b1;
    Z_i     = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (Valid_o !== 1'b1 || Cordic_z !== snap || Mode_o !== 1'b0 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b z=%h mode=%b busy=%b, want 1 %h 0 1",
                 i, Valid_o, Cordic_z, Mode_o, Busy, snap);
      end
    end
    Enable = 1'b1;
    drain("stall");
    checks++;
    if (n_out - start != 4) begin
      errors++;
      $display("FAIL stall_count: outputs=%0d, want 4", n_out - start);
    end
  endtask

  task automatic test_mixed();
    int start;
    start = n_out;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(16'd4096, 1'b0);
      else            drive(16'd0, 1'b1);
      step();
    end
    drain("mixed");
    checks++;
    if (n_out - start != 8) begin
      errors++;
      $display("FAIL mixed_count: outputs=%0d, want 8", n_out - start);
    end
  endtask

  task automatic test_bubbles();
    logic [3:0] pat;
    logic       exp_v;
    pat = 4'b1001;
    for (int k = 1; k <= 23; k++) begin
      if (k - 1 < 4 && pat[k-1]) drive(16'(k * 3000 + 700), 1'b0);
      else                        idle();
      step();
      checks++;
      if (Busy !== (k <= 19)) begin
        errors++;
        $display("FAIL bubble_busy_e%0d: Busy=%b, want %b", k, Busy, (k <= 19));
      end
      if (k >= 15 && k <= 20) begin
        exp_v = (k >= 16 && k <= 19) ? pat[k-16] : 1'b0;
        checks++;
        if (Valid_o !== exp_v) begin
          errors++;
          $display("FAIL bubble_valid_e%0d: Valid_o=%b, want %b", k, Valid_o, exp_v);
        end
      end
    end
    drain("bubbles");
  endtask

  task automatic test_reset_midflight();
    int edges;
    for (int i = 0; i < 20; i++) begin
      drive(16'(i * 1500), 1'b0);
      step();
    end
    checks++;
    if (Valid_o !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_full: valid=%b busy=%b, want 1 1", Valid_o, Busy);
    end
    #2;
    Reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (Valid_o !== 1'b0 || Busy !== 1'b0 || Cordic_z !== 16'h0 || Mode_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: valid=%b busy=%b z=%h mode=%b, want 0 0 0000 0",
               Valid_o, Busy, Cordic_z, Mode_o);
    end
    repeat (2) step();
    Reset = 1'b1;
    drive(16'd500, 1'b0);
    step();
    edges = 1;
    idle();
    while (Valid_o !== 1'b1 && edges < 40) begin
      step();
      edges++;
    end
    checks++;
    if (edges != 16) begin
      errors++;
      $display("FAIL rst_latency: edges=%0d, want 16", edges);
    end
    drain("rst");
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    en_edges = 0;
    last_en  = 1'b0;
    n_out    = 0;
    last_z   = '0;
    Reset    = 1'b0;
    Enable   = 1'b0;
    Valid_i  = 1'b0;
    Mode_i   = 1'b0;
    Z_i      = '0;
    Dir_i    = '1;
    test_reset();
    test_rotation();
    test_vectoring();
    test_stall();
    test_mixed();
    test_bubbles();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
